// File: rtl/b_countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.

package b_countdown_timer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/b_countdown_timer_core.sv
// Count register with load / reload / decrement mux and a ==1 detector used
// by the controller to spot the terminal step one cycle ahead.

module b_down_core
   import b_countdown_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec_en,
   input  logic             reload_en,
   output logic [WIDTH-1:0] count,
   output logic             is_one
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;

   // Load has priority; the controller never asserts reload and decrement together.
   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      if (load_en) begin
         count_d  = load_value;
         reload_d = load_value;
      end else if (reload_en) begin
         count_d = reload_q;
      end else if (dec_en) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= '0;
         reload_q <= '0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign count  = count_q;
   assign is_one = (count_q == WIDTH'(1));

endmodule

// File: rtl/b_countdown_timer.sv
// Loadable down-counter/timer: valid/ready load, one-shot or auto-reload,
// registered one-cycle terminal-count strobe.

module b_countdown_timer
   import b_countdown_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             auto_reload,
   input  logic             enable,
   input  logic             abort,
   output logic [WIDTH-1:0] count_out,
   output logic             busy,
   output logic             done,
   output logic             tc_pulse
);

   state_e state_q, state_d;
   logic   mode_q, mode_d;
   logic   tc_q, tc_d;
   logic   load_en, dec_en, reload_en;
   logic   is_one;
   logic   accept;

   assign load_ready = (state_q != ST_RUN);
   assign accept     = load_valid && load_ready;

   b_down_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_en    (load_en),
      .load_value (load_value),
      .dec_en     (dec_en),
      .reload_en  (reload_en),
      .count      (count_out),
      .is_one     (is_one)
   );

   // Abort wins over counting; a one-shot terminal step is a plain decrement to zero.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      tc_d      = 1'b0;
      load_en   = 1'b0;
      dec_en    = 1'b0;
      reload_en = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               load_en = 1'b1;
               mode_d  = auto_reload;
               if (load_value == '0) begin
                  state_d = ST_DONE;
                  tc_d    = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (enable) begin
               if (is_one) begin
                  tc_d = 1'b1;
                  if (mode_q) begin
                     reload_en = 1'b1;
                  end else begin
                     dec_en  = 1'b1;
                     state_d = ST_DONE;
                  end
               end else begin
                  dec_en = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         tc_q    <= tc_d;
      end
   end

   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign tc_pulse = tc_q;

endmodule

// File: tb/tb_b_countdown_timer.sv
// Self-checking bench for b_countdown_timer: a cycle-level behavioural model
// compared on every clock, plus literal expectations pinning model and DUT.

module tb_b_countdown_timer;

   logic       clk;
   logic       reset_n;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_value;
   logic       auto_reload;
   logic       enable;
   logic       abort;
   logic [7:0] count_out;
   logic       busy;
   logic       done;
   logic       tc_pulse;

   int checks   = 0;
   int failures = 0;

   // Behavioural model of the timer's observable state
   int m_count;
   int m_reload;
   bit m_running;
   bit m_done;
   bit m_periodic;
   bit m_tc;

   b_countdown_timer #(.WIDTH(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_value  (load_value),
      .auto_reload (auto_reload),
      .enable      (enable),
      .abort       (abort),
      .count_out   (count_out),
      .busy        (busy),
      .done        (done),
      .tc_pulse    (tc_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_count    = 0;
      m_reload   = 0;
      m_running  = 1'b0;
      m_done     = 1'b0;
      m_periodic = 1'b0;
      m_tc       = 1'b0;
   endtask

   // One clock of timer behaviour, stated from the rules rather than an FSM
   task automatic modelStep();
      m_tc = 1'b0;
      if (load_valid && !m_running) begin
         m_periodic = auto_reload;
         m_count    = int'(load_value);
         if (load_value == 8'd0) begin
            m_done = 1'b1;
            m_tc   = 1'b1;
         end else begin
            m_reload  = int'(load_value);
            m_running = 1'b1;
            m_done    = 1'b0;
         end
      end else if (m_running) begin
         if (abort) begin
            m_running = 1'b0;
         end else if (enable) begin
            if (m_count == 1) begin
               m_tc = 1'b1;
               if (m_periodic) begin
                  m_count = m_reload;
               end else begin
                  m_count   = 0;
                  m_running = 1'b0;
                  m_done    = 1'b1;
               end
            end else begin
               m_count = m_count - 1;
            end
         end
      end
   endtask

   task automatic compareAll();
      checkOutput("count_out", int'(count_out), m_count);
      checkOutput("busy", int'(busy), int'(m_running));
      checkOutput("done", int'(done), int'(m_done));
      checkOutput("tc_pulse", int'(tc_pulse), int'(m_tc));
      checkOutput("load_ready", int'(load_ready), int'(!m_running));
   endtask

   // Drive one cycle of inputs, advance model at the edge, compare at the falling edge
   task automatic applyStimulus(input logic lv, input logic [7:0] val, input logic ar,
                                input logic en, input logic ab);
      load_valid  = lv;
      load_value  = val;
      auto_reload = ar;
      enable      = en;
      abort       = ab;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      compareAll();
   endtask

   initial begin
      int tcCount;
      int tcAt;

      reset_n     = 1'b0;
      load_valid  = 1'b0;
      load_value  = 8'd0;
      auto_reload = 1'b0;
      enable      = 1'b0;
      abort       = 1'b0;
      modelReset();

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_count", int'(count_out), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_tc", int'(tc_pulse), 0);
      checkOutput("rst_ready", int'(load_ready), 1);
      reset_n = 1'b1;
      applyStimulus(0, 8'd0, 0, 0, 0);

      // One-shot load 3: 3,2,1,0 with tc arriving alongside 0
      applyStimulus(1, 8'd3, 0, 1, 0);
      checkOutput("os_load_count", int'(count_out), 3);
      checkOutput("os_model_count", m_count, 3);
      applyStimulus(0, 8'd0, 0, 1, 0);
      applyStimulus(0, 8'd0, 0, 1, 0);
      checkOutput("os_count_1", int'(count_out), 1);
      applyStimulus(0, 8'd0, 0, 1, 0);
      checkOutput("os_count_0", int'(count_out), 0);
      checkOutput("os_tc", int'(tc_pulse), 1);
      checkOutput("os_done", int'(done), 1);
      checkOutput("os_busy", int'(busy), 0);
      checkOutput("os_model_tc", int'(m_tc), 1);
      applyStimulus(0, 8'd0, 0, 1, 0);
      checkOutput("os_tc_after", int'(tc_pulse), 0);

      // Auto-reload 4 over 12 enabled cycles
      applyStimulus(1, 8'd4, 1, 1, 0);
      checkOutput("ar_load_done_clr", int'(done), 0);
      tcCount = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 8'd0, 0, 1, 0);
         if (tc_pulse) tcCount++;
         checkOutput("ar_busy", int'(busy), 1);
      end
      checkOutput("ar_tc_count", tcCount, 3);
      checkOutput("ar_count_reload", int'(count_out), 4);
      applyStimulus(0, 8'd0, 0, 1, 1);
      checkOutput("ar_abort_busy", int'(busy), 0);

      // Enable gaps then abort with load_valid high
      applyStimulus(1, 8'd10, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 8'd0, 0, 0, 0);
         applyStimulus(0, 8'd0, 0, 1, 0);
      end
      checkOutput("gap_count", int'(count_out), 6);
      checkOutput("gap_model_count", m_count, 6);
      applyStimulus(1, 8'd7, 0, 1, 1);
      checkOutput("abort_count", int'(count_out), 6);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_tc", int'(tc_pulse), 0);
      checkOutput("abort_ready", int'(load_ready), 1);
      applyStimulus(1, 8'd7, 0, 1, 0);
      checkOutput("abort_reload_count", int'(count_out), 7);
      applyStimulus(0, 8'd0, 0, 1, 1);
      applyStimulus(0, 8'd0, 0, 1, 1);

      // Zero load: immediate terminal event
      applyStimulus(1, 8'd0, 0, 1, 0);
      checkOutput("zero_tc", int'(tc_pulse), 1);
      checkOutput("zero_done", int'(done), 1);
      checkOutput("zero_count", int'(count_out), 0);
      applyStimulus(0, 8'd0, 0, 1, 0);

      // Full-scale one-shot: tc on the 255th enabled cycle
      applyStimulus(1, 8'd255, 0, 1, 0);
      checkOutput("max_count", int'(count_out), 255);
      tcAt = 0;
      for (int i = 1; i <= 260; i++) begin
         applyStimulus(0, 8'd0, 0, 1, 0);
         if (tc_pulse && tcAt == 0) tcAt = i;
      end
      checkOutput("max_tc_cycle", tcAt, 255);

      // Reload value 1: tc every cycle
      applyStimulus(1, 8'd1, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 8'd0, 0, 1, 0);
         checkOutput("rel1_tc", int'(tc_pulse), 1);
         checkOutput("rel1_count", int'(count_out), 1);
      end
      applyStimulus(0, 8'd0, 0, 1, 1);

      // load_valid held through RUN, accepted only once DONE
      applyStimulus(1, 8'd2, 0, 1, 0);
      applyStimulus(1, 8'd9, 0, 1, 0);
      checkOutput("hs_no_accept", int'(count_out), 1);
      applyStimulus(1, 8'd9, 0, 1, 0);
      checkOutput("hs_done", int'(done), 1);
      applyStimulus(1, 8'd9, 0, 1, 0);
      checkOutput("hs_accept_count", int'(count_out), 9);
      checkOutput("hs_done_clr", int'(done), 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 8'd0, 0, 1, 0);
      checkOutput("pre_rst_count", int'(count_out), 5);

      // Asynchronous reset mid-count
      #2 reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput("arst_count", int'(count_out), 0);
      checkOutput("arst_busy", int'(busy), 0);
      checkOutput("arst_tc", int'(tc_pulse), 0);
      checkOutput("arst_ready", int'(load_ready), 1);
      checkOutput("arst_done", int'(done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(0, 8'd0, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
